pocket_event_detector: RTL and testbench

Consumes the per-pixel hole-hit stream (Hit_Hole_DR, Hole_ID) and the per-ball drawing requests, and turns pixel overlaps into discrete "ball i fell into hole h" events for the game controller. It accumulates overlap counts for each ball during a frame. At start of frame it scans the results and queues one event per newly pocketed ball into a small FIFO with a valid/ready handshake. It sits between the VGA hole/ball muxes and the game-state logic.

---
 rtl/pocket_event_detector_if.sv | 12 +
 rtl/pocket_event_detector.sv | 147 ++++++++++++++
 tb/tb_pocket_event_detector.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pocket_event_detector_if.sv
// Event handshake between the pocket detector (master) and the game controller (slave).
interface pocket_event_detector_if #(
    parameter int BW = 4
);
    logic          event_valid;
    logic          event_ready;
    logic [BW-1:0] event_ball;
    logic [2:0]    event_hole;

    modport master (output event_valid, event_ball, event_hole, input event_ready);
    modport slave  (input event_valid, event_ball, event_hole, output event_ready);
endinterface

// File: rtl/pocket_event_detector.sv
// Turns per-pixel ball/hole overlaps into queued "ball i fell into hole h" events.
// Counts accumulate during a frame; a start-of-frame scan enqueues newly pocketed balls.
module pocket_event_detector #(
    parameter int NUM_BALLS  = 16,
    parameter int MIN_PIXELS = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    clear_all,
    input  logic                    Hit_Hole_DR,
    input  logic [2:0]              Hole_ID,
    input  logic [NUM_BALLS-1:0]    Ball_DR,
    pocket_event_detector_if.master evt,
    output logic [NUM_BALLS-1:0]    pocketed_mask,
    output logic                    overflow
);
    localparam int BW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = PW - 1;

    typedef enum logic {IDLE, SCAN} state_t;

    typedef struct packed {
        logic [BW-1:0] ball;
        logic [2:0]    hole;
    } entry_t;

    state_t        state, state_next;
    logic [BW-1:0] k;
    logic [7:0]    cnt       [NUM_BALLS];
    logic [2:0]    hole      [NUM_BALLS];
    logic [7:0]    snap_cnt  [NUM_BALLS];
    logic [2:0]    snap_hole [NUM_BALLS];
    entry_t        mem       [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          qual_hit, frame_start, last_ball;
    logic          empty, full, pop;
    logic          candidate, push, refuse;
    entry_t        head;

    assign qual_hit    = Hit_Hole_DR && (Hole_ID != 3'd0) && (Hole_ID != 3'd7);
    assign frame_start = startOfFrame && (state == IDLE);
    assign last_ball   = (k == BW'(NUM_BALLS - 1));

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && evt.event_ready;
    assign head  = mem[rd_ptr[AW-1:0]];

    assign evt.event_valid = !empty;
    assign evt.event_ball  = head.ball;
    assign evt.event_hole  = head.hole;

    // Live counters and frame snapshots; a hit in the snapshot cycle is dropped.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                cnt[i]       <= '0;
                hole[i]      <= '0;
                snap_cnt[i]  <= '0;
                snap_hole[i] <= '0;
            end
        end else if (clear_all) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                cnt[i]       <= '0;
                hole[i]      <= '0;
                snap_cnt[i]  <= '0;
                snap_hole[i] <= '0;
            end
        end else if (frame_start) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                snap_cnt[i]  <= cnt[i];
                snap_hole[i] <= hole[i];
                cnt[i]       <= '0;
            end
        end else if (qual_hit) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (Ball_DR[i] && !pocketed_mask[i]) begin
                    if (cnt[i] != 8'hFF) cnt[i] <= cnt[i] + 8'd1;
                    if (cnt[i] == 8'd0)  hole[i] <= Hole_ID;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
            k     <= '0;
        end else if (clear_all) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_next;
            k     <= (state == SCAN && !last_ball) ? k + 1'b1 : '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (startOfFrame) state_next = SCAN;
            SCAN:    if (last_ball)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    // NOTE: every always_comb output gets a default first so no path holds a value (no latch).
    always_comb begin
        candidate = 1'b0;
        push      = 1'b0;
        refuse    = 1'b0;
        if (state == SCAN) begin
            candidate = (snap_cnt[k] >= 8'(MIN_PIXELS)) && !pocketed_mask[k];
            push      = candidate && (!full || pop);
            refuse    = candidate && full && !pop;
        end
    end

    // NOTE: FIFO storage is reset too, so the show-ahead head reads 0 straight out of reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            pocketed_mask <= '0;
            overflow      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (clear_all) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            pocketed_mask <= '0;
            overflow      <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= entry_t'{ball: k, hole: snap_hole[k]};
                wr_ptr              <= wr_ptr + 1'b1;
                pocketed_mask[k]    <= 1'b1;
            end
            if (pop)    rd_ptr   <= rd_ptr + 1'b1;
            if (refuse) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pocket_event_detector.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences,
// and random frames compared against a frame-level behavioural model.
module tb_pocket_event_detector;
    localparam int NUM_BALLS  = 16;
    localparam int MIN_PIXELS = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int BW         = 4;

    logic                 clk = 1'b0;
    logic                 resetN, startOfFrame, clear_all, Hit_Hole_DR;
    logic [2:0]           Hole_ID;
    logic [NUM_BALLS-1:0] Ball_DR, pocketed_mask;
    logic                 overflow;

    pocket_event_detector_if #(.BW(BW)) evt ();

    pocket_event_detector #(
        .NUM_BALLS (NUM_BALLS),
        .MIN_PIXELS(MIN_PIXELS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .clear_all    (clear_all),
        .Hit_Hole_DR  (Hit_Hole_DR),
        .Hole_ID      (Hole_ID),
        .Ball_DR      (Ball_DR),
        .evt          (evt),
        .pocketed_mask(pocketed_mask),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    int n_checks = 0;
    int n_fail   = 0;
    int got_ball[$], got_hole[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pixels(input logic [NUM_BALLS-1:0] balls, input logic hit,
                          input logic [2:0] hole, input int n);
        for (int i = 0; i < n; i++) begin
            Ball_DR = balls; Hit_Hole_DR = hit; Hole_ID = hole;
            tick();
        end
        Ball_DR = '0; Hit_Hole_DR = 1'b0; Hole_ID = 3'd0;
    endtask

    // Pulse startOfFrame and wait out the whole scan.
    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (NUM_BALLS) tick();
    endtask

    task automatic do_clear();
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
    endtask

    task automatic drain();
        got_ball.delete();
        got_hole.delete();
        evt.event_ready = 1'b1;
        for (int c = 0; c < 2 * FIFO_DEPTH; c++) begin
            if (evt.event_valid) begin
                got_ball.push_back(int'(evt.event_ball));
                got_hole.push_back(int'(evt.event_hole));
            end
            tick();
        end
        evt.event_ready = 1'b0;
    endtask

    typedef struct {
        string      name;
        int         ball;
        logic       hit_a;
        logic [2:0] hole_a;
        int         n_a;
        logic       hit_b;
        logic [2:0] hole_b;
        int         n_b;
        logic       exp_evt;
        logic [2:0] exp_hole;
    } vec_t;

    vec_t vec[10];

    // Frame-level reference: plain counts per ball, ordered candidate list at the boundary.
    int                   m_cnt[NUM_BALLS];
    int                   m_hole[NUM_BALLS];
    logic [NUM_BALLS-1:0] m_mask;
    logic                 m_ovf;
    int                   exp_ball[$], exp_hole[$];

    task automatic model_clear();
        for (int i = 0; i < NUM_BALLS; i++) begin
            m_cnt[i] = 0; m_hole[i] = 0;
        end
        m_mask = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_pixel(input logic [NUM_BALLS-1:0] balls, input logic hit, input int hole);
        if (hit && hole >= 1 && hole <= 6) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (balls[i] && !m_mask[i]) begin
                    if (m_cnt[i] == 0) m_hole[i] = hole;
                    m_cnt[i]++;
                end
            end
        end
    endtask

    task automatic model_frame();
        exp_ball.delete();
        exp_hole.delete();
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (((m_cnt[i] > 255) ? 255 : m_cnt[i]) >= MIN_PIXELS && !m_mask[i]) begin
                if (exp_ball.size() < FIFO_DEPTH) begin
                    exp_ball.push_back(i);
                    exp_hole.push_back(m_hole[i]);
                    m_mask[i] = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            m_cnt[i] = 0;
        end
    endtask

    initial begin
        logic [NUM_BALLS-1:0] focus, b;
        int                   npix, h;
        logic                 hit;

        resetN = 1'b0; startOfFrame = 1'b0; clear_all = 1'b0;
        Hit_Hole_DR = 1'b0; Hole_ID = 3'd0; Ball_DR = '0;
        evt.event_ready = 1'b0;

        vec[0] = '{"thr_over",     3, 1'b1, 3'd5, 20, 1'b0, 3'd0, 0,  1'b1, 3'd5};
        vec[1] = '{"thr_below",    0, 1'b1, 3'd2, 15, 1'b0, 3'd0, 0,  1'b0, 3'd0};
        vec[2] = '{"thr_exact",    0, 1'b1, 3'd2, 16, 1'b0, 3'd0, 0,  1'b1, 3'd2};
        vec[3] = '{"hole0",        7, 1'b1, 3'd0, 50, 1'b0, 3'd0, 0,  1'b0, 3'd0};
        vec[4] = '{"hole7",        7, 1'b1, 3'd7, 50, 1'b0, 3'd0, 0,  1'b0, 3'd0};
        vec[5] = '{"first_hole",   9, 1'b1, 3'd2, 1,  1'b1, 3'd4, 20, 1'b1, 3'd2};
        vec[6] = '{"no_hit",       4, 1'b0, 3'd4, 40, 1'b0, 3'd0, 0,  1'b0, 3'd0};
        vec[7] = '{"skip_invalid", 12, 1'b1, 3'd0, 5, 1'b1, 3'd3, 16, 1'b1, 3'd3};
        vec[8] = '{"mixed_short",  1, 1'b1, 3'd1, 8,  1'b1, 3'd7, 30, 1'b0, 3'd0};
        vec[9] = '{"last_ball",    15, 1'b1, 3'd6, 200, 1'b0, 3'd0, 0, 1'b1, 3'd6};

        repeat (2) tick();
        check("rst.valid", evt.event_valid, 0);
        check("rst.ball", evt.event_ball, 0);
        check("rst.hole", evt.event_hole, 0);
        check("rst.mask", pocketed_mask, 0);
        check("rst.ovf", overflow, 0);
        resetN = 1'b1;
        tick();

        foreach (vec[i]) begin
            do_clear();
            pixels(NUM_BALLS'(1) << vec[i].ball, vec[i].hit_a, vec[i].hole_a, vec[i].n_a);
            pixels(NUM_BALLS'(1) << vec[i].ball, vec[i].hit_b, vec[i].hole_b, vec[i].n_b);
            frame();
            check($sformatf("%s.valid", vec[i].name), evt.event_valid, vec[i].exp_evt);
            check($sformatf("%s.mask", vec[i].name), pocketed_mask,
                  vec[i].exp_evt ? (NUM_BALLS'(1) << vec[i].ball) : '0);
            if (vec[i].exp_evt) begin
                check($sformatf("%s.ball", vec[i].name), evt.event_ball, vec[i].ball);
                check($sformatf("%s.hole", vec[i].name), evt.event_hole, vec[i].exp_hole);
            end
            drain();
        end

        // Event latency: startOfFrame at T, ball 3 visible at T+5, popped at T+5.
        do_clear();
        pixels(16'h0008, 1'b1, 3'd5, 20);
        evt.event_ready = 1'b1;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (3) tick();
        check("lat.t4_valid", evt.event_valid, 0);
        tick();
        check("lat.t5_valid", evt.event_valid, 1);
        check("lat.t5_ball", evt.event_ball, 3);
        check("lat.t5_hole", evt.event_hole, 5);
        check("lat.t5_mask", pocketed_mask, 16'h0008);
        tick();
        check("lat.popped", evt.event_valid, 0);
        repeat (NUM_BALLS) tick();
        evt.event_ready = 1'b0;

        // 270 pixels wraps an unsaturated 8-bit counter to 14, below threshold.
        do_clear();
        pixels(16'h0001, 1'b1, 3'd2, 270);
        frame();
        drain();
        check("sat.count", got_ball.size(), 1);
        if (got_ball.size() > 0) check("sat.ball", got_ball[0], 0);
        pixels(16'h0001, 1'b1, 3'd2, 300);
        frame();
        drain();
        check("sat.no_repeat", got_ball.size(), 0);

        // Overflow: six candidates, only four slots, nobody popping.
        do_clear();
        pixels(16'h003F, 1'b1, 3'd3, 20);
        frame();
        check("ovf.flag", overflow, 1);
        check("ovf.mask", pocketed_mask, 16'h000F);
        evt.event_ready = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            check($sformatf("ovf.b2b%0d_valid", i), evt.event_valid, 1);
            check($sformatf("ovf.b2b%0d_ball", i), evt.event_ball, i);
            tick();
        end
        evt.event_ready = 1'b0;
        check("ovf.empty", evt.event_valid, 0);
        pixels(16'h0030, 1'b1, 3'd4, 20);
        frame();
        drain();
        check("retry.count", got_ball.size(), 2);
        if (got_ball.size() == 2) begin
            check("retry.ball4", got_ball[0], 4);
            check("retry.ball5", got_ball[1], 5);
            check("retry.hole", got_hole[1], 4);
        end
        check("retry.mask", pocketed_mask, 16'h003F);
        check("retry.ovf_sticky", overflow, 1);

        // clear_all mid-scan: ball 6 evaluated at T+7, visible T+8, cleared at T+9.
        pixels(16'h00C0, 1'b1, 3'd1, 20);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (7) tick();
        check("clr.pre_valid", evt.event_valid, 1);
        check("clr.pre_mask", pocketed_mask, 16'h007F);
        do_clear();
        check("clr.valid", evt.event_valid, 0);
        check("clr.mask", pocketed_mask, 0);
        check("clr.ovf", overflow, 0);
        repeat (NUM_BALLS) tick();
        check("clr.no_requeue", evt.event_valid, 0);

        // startOfFrame during SCAN must not clear the live counts.
        pixels(16'h0004, 1'b1, 3'd1, 10);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        for (int i = 0; i < 10; i++) begin
            Ball_DR = 16'h0004; Hit_Hole_DR = 1'b1; Hole_ID = 3'd1;
            startOfFrame = (i == 4);
            tick();
        end
        Ball_DR = '0; Hit_Hole_DR = 1'b0; Hole_ID = 3'd0; startOfFrame = 1'b0;
        repeat (NUM_BALLS) tick();
        check("midsof.first", evt.event_valid, 0);
        pixels(16'h0004, 1'b1, 3'd1, 6);
        frame();
        check("midsof.valid", evt.event_valid, 1);
        check("midsof.ball", evt.event_ball, 2);
        drain();

        // Asynchronous reset mid-scan with three entries queued.
        do_clear();
        pixels(16'h000E, 1'b1, 3'd6, 20);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (4) tick();
        check("arst.pre_valid", evt.event_valid, 1);
        check("arst.pre_mask", pocketed_mask, 16'h000E);
        #2 resetN = 1'b0;
        #1;
        check("arst.valid", evt.event_valid, 0);
        check("arst.ball", evt.event_ball, 0);
        check("arst.hole", evt.event_hole, 0);
        check("arst.mask", pocketed_mask, 0);
        check("arst.ovf", overflow, 0);
        tick();
        resetN = 1'b1;
        tick();
        frame();
        check("arst.after", evt.event_valid, 0);

        // Random frames against the frame-level model.
        for (int f = 0; f < 12; f++) begin
            if (f % 4 == 0) begin
                do_clear();
                model_clear();
            end
            focus = '0;
            repeat (6) focus[$urandom_range(0, NUM_BALLS - 1)] = 1'b1;
            npix = $urandom_range(10, 60);
            for (int p = 0; p < npix; p++) begin
                b   = NUM_BALLS'($urandom) & focus;
                h   = $urandom_range(0, 7);
                hit = ($urandom_range(0, 3) != 0);
                model_pixel(b, hit, h);
                Ball_DR = b; Hit_Hole_DR = hit; Hole_ID = 3'(h);
                tick();
            end
            Ball_DR = '0; Hit_Hole_DR = 1'b0; Hole_ID = 3'd0;
            frame();
            model_frame();
            check($sformatf("rnd%0d.mask", f), pocketed_mask, m_mask);
            check($sformatf("rnd%0d.ovf", f), overflow, m_ovf);
            drain();
            check($sformatf("rnd%0d.count", f), got_ball.size(), exp_ball.size());
            for (int i = 0; i < exp_ball.size(); i++) begin
                if (i < got_ball.size()) begin
                    check($sformatf("rnd%0d.ball%0d", f, i), got_ball[i], exp_ball[i]);
                    check($sformatf("rnd%0d.hole%0d", f, i), got_hole[i], exp_hole[i]);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
